// File: rtl/klein_pkg.sv
// KLEIN-96 serial controller shared definitions.
// Round geometry, FSM states and select-table constants.
package klein_pkg;

   localparam int NROUNDS = 20;
   localparam int NBYTES  = 12;
   localparam int RCYC    = 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      FINAL = 2'd3
   } state_t;

   // Byte positions within a round that steer the datapath.
   localparam logic [3:0] C_RCON  = 4'd0;
   localparam logic [3:0] C_KSB0  = 4'd2;
   localparam logic [3:0] C_KSB1  = 4'd3;
   localparam logic [3:0] C_FX0   = 4'd4;
   localparam logic [3:0] C_FX1   = 4'd7;
   localparam logic [3:0] C_SR    = 4'd6;
   localparam logic [3:0] C_MN0   = 4'd9;
   localparam logic [3:0] C_MN1   = 4'd10;
   localparam logic [3:0] C_MN2   = 4'd11;
   localparam logic [3:0] C_SPILL = 4'd12;

   localparam logic [0:3] SELS_SR  = 4'b1000;
   localparam logic [0:3] SELS_MN0 = 4'b0100;
   localparam logic [0:3] SELS_MN1 = 4'b0010;
   localparam logic [0:3] SELS_MN2 = 4'b0001;

   localparam logic [0:4] SELK_RC = 5'b00001;
   localparam logic [0:4] SELK_SB = 5'b10100;
   localparam logic [0:4] SELK_FX = 5'b01010;
   localparam logic [0:4] SELK_SP = 5'b00100;

endpackage

// File: rtl/klein96_serial_ctrl_if.sv
// Control bundle between the KLEIN-96 sequencer and its datapath.
// master drives selects, slave (datapath/requester) drives start.
interface klein96_serial_ctrl_if;

   logic       start;
   logic       in_req;
   logic       round0;
   logic       round1;
   logic [0:4] round;
   logic [0:3] sels;
   logic [0:4] selk;
   logic       out_valid;
   logic       busy;
   logic       done;

   modport master (
      input  start,
      output in_req, round0, round1, round,
      output sels, selk, out_valid, busy, done
   );

   modport slave (
      output start,
      input  in_req, round0, round1, round,
      input  sels, selk, out_valid, busy, done
   );

endinterface

// File: rtl/klein_sel_rom.sv
// Per-byte select decode for one KLEIN-96 round.
// Outputs are zero whenever phase is not a round.
module klein_sel_rom
   import klein_pkg::*;
(
   input  logic [3:0] c,
   input  logic       phase,
   output logic [0:3] sels,
   output logic [0:4] selk
);

   always_comb begin
      sels = '0;
      selk = '0;
      if (phase) begin
         unique case (1'b1)
            c == C_SR:  sels = SELS_SR;
            c == C_MN0: sels = SELS_MN0;
            c == C_MN1: sels = SELS_MN1;
            c == C_MN2: sels = SELS_MN2;
            default:    sels = '0;
         endcase
         unique case (1'b1)
            c == C_RCON:                 selk = SELK_RC;
            c == C_KSB0 || c == C_KSB1:  selk = SELK_SB;
            c >= C_FX0 && c <= C_FX1:    selk = SELK_FX;
            c == C_SPILL:                selk = SELK_SP;
            default:                     selk = '0;
         endcase
      end
   end

endmodule

// File: rtl/klein96_serial_ctrl.sv
// Byte-serial KLEIN-96 sequencer: load, NROUNDS rounds, unload.
// Outputs are decoded from next-state and registered.
module klein96_serial_ctrl #(
   parameter int NROUNDS = klein_pkg::NROUNDS,
   parameter int NBYTES  = klein_pkg::NBYTES,
   parameter int RCYC    = klein_pkg::RCYC
) (
   input  logic                        ck,
   input  logic                        rst,
   klein96_serial_ctrl_if.master       b
);

   typedef klein_pkg::state_t state_t;

   localparam logic [3:0] CLAST = 4'(NBYTES - 1);
   localparam logic [3:0] CWRAP = 4'(RCYC - 1);
   localparam logic [4:0] RLAST = 5'(NROUNDS);

   state_t     st, st_n;
   logic [3:0] c, c_n;
   logic [4:0] r, r_n;
   logic       run_n, key_n, load_n;
   logic [0:3] sels_n;
   logic [0:4] selk_n;

   always_comb begin
      st_n = st;
      c_n  = c;
      r_n  = r;
      case (st)
         klein_pkg::IDLE: begin
            if (b.start) begin
               st_n = klein_pkg::LOAD;
               c_n  = '0;
            end
         end
         klein_pkg::LOAD: begin
            if (c == CLAST) begin
               st_n = klein_pkg::ROUND;
               c_n  = '0;
               r_n  = 5'd1;
            end else begin
               c_n = c + 4'd1;
            end
         end
         klein_pkg::ROUND: begin
            if (c == CWRAP) begin
               c_n = '0;
               if (r == RLAST) begin
                  st_n = klein_pkg::FINAL;
                  r_n  = '0;
               end else begin
                  r_n = r + 5'd1;
               end
            end else begin
               c_n = c + 4'd1;
            end
         end
         klein_pkg::FINAL: begin
            if (c == CLAST) begin
               st_n = klein_pkg::IDLE;
               c_n  = '0;
            end else begin
               c_n = c + 4'd1;
            end
         end
         default: begin
            st_n = klein_pkg::IDLE;
            c_n  = '0;
            r_n  = '0;
         end
      endcase
   end

   // Round 1 re-streams the key bytes alongside key injection.
   assign load_n = st_n == klein_pkg::LOAD;
   assign run_n  = st_n == klein_pkg::ROUND;
   assign key_n  = run_n && r_n == 5'd1 && c_n <= CLAST;

   klein_sel_rom u_rom (
      .c     (c_n),
      .phase (run_n),
      .sels  (sels_n),
      .selk  (selk_n)
   );

   always_ff @(posedge ck) begin
      if (rst) begin
         st          <= klein_pkg::IDLE;
         c           <= '0;
         r           <= '0;
         b.in_req    <= 1'b0;
         b.round0    <= 1'b0;
         b.round1    <= 1'b0;
         b.round     <= '0;
         b.sels      <= '0;
         b.selk      <= '0;
         b.out_valid <= 1'b0;
         b.busy      <= 1'b0;
         b.done      <= 1'b0;
      end else begin
         st          <= st_n;
         c           <= c_n;
         r           <= r_n;
         b.in_req    <= load_n || key_n;
         b.round0    <= load_n;
         b.round1    <= key_n;
         b.round     <= run_n ? r_n : 5'd0;
         b.sels      <= sels_n;
         b.selk      <= selk_n;
         b.out_valid <= st_n == klein_pkg::FINAL;
         b.busy      <= st_n != klein_pkg::IDLE;
         b.done      <= st == klein_pkg::FINAL &&
                        st_n == klein_pkg::IDLE;
      end
   end

endmodule
